grid_router_tx_framer: RTL and testbench

Packet framer that sits directly upstream of the grid router transmit path. It accepts 120-bit router packets over a valid/ready handshake and slices each one into 15-bit beats. Each beat is driven as three 6-bit lane groups (`ig1`, `ig2`, `ig3`), one beat per `pclk`, and these groups feed the GCR encoders and serializers. Between frames it emits in-band IDLE and ALIGN control groups so the far-end receiver can find frame and word boundaries.

---
 rtl/grid_router_tx_framer_if.sv | 21 ++
 rtl/grid_router_tx_framer.sv | 143 ++++++++++++++
 tb/tb_grid_router_tx_framer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/grid_router_tx_framer_if.sv
// Packet-side handshake and lane-group outputs of the grid router transmit framer.
// Handshake: a packet transfers on a pclk edge where pkt_valid and pkt_ready are both high.
interface grid_router_tx_framer_if;
    logic [119:0] pkt_i;
    logic         pkt_valid;
    logic         pkt_ready;
    logic [5:0]   ig1;
    logic [5:0]   ig2;
    logic [5:0]   ig3;
    logic         busy;

    modport master (
        output pkt_i, pkt_valid,
        input  pkt_ready, ig1, ig2, ig3, busy
    );

    modport slave (
        input  pkt_i, pkt_valid,
        output pkt_ready, ig1, ig2, ig3, busy
    );
endinterface

// File: rtl/grid_router_tx_framer.sv
// Slices 120-bit packets into 15-bit beats framed by SOF, with periodic ALIGN between frames.
// Define GRID_ROUTER_FRAMER_CHKSUM_EN to append a 15-bit checksum beat to every frame.
module grid_router_tx_framer #(
    parameter int unsigned pAlignInterval = 64
) (
    input  logic                    pclk,
    input  logic                    rst,
    grid_router_tx_framer_if.slave  tx,
    output logic [2:0]              state_o
);
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ALIGN = 3'd1,
        ST_SOF   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CKSUM = 3'd4
    } state_t;

    localparam logic [15:0] ALIGN_MAX  = 16'(pAlignInterval);
    localparam logic [4:0]  CODE_IDLE  = 5'h00;
    localparam logic [4:0]  CODE_SOF   = 5'h1C;
    localparam logic [4:0]  CODE_ALIGN = 5'h15;

    function automatic logic [17:0] data_groups(input logic [14:0] b);
        return {1'b0, b[14:10], 1'b0, b[9:5], 1'b0, b[4:0]};
    endfunction

    function automatic logic [17:0] ctrl_groups(input logic [4:0] c);
        return {1'b1, c, 1'b1, c, 1'b1, c};
    endfunction

    state_t         state_q;
    logic [119:0]   shift_q;
    logic [2:0]     beat_q;
    logic [15:0]    align_cnt_q;
    logic [15:0]    align_cnt_d;
    logic [17:0]    lanes_q;
    logic           busy_q;
    logic           align_due;
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
    logic [14:0]    cksum_q;
    logic [14:0]    cksum_d;

    // Accumulates the beat being loaded into the lane register this cycle.
    assign cksum_d = cksum_q + shift_q[14:0];
`endif

    assign align_due    = (align_cnt_q == ALIGN_MAX);
    assign tx.pkt_ready = (state_q == ST_IDLE) && !align_due;
    assign tx.ig1       = lanes_q[5:0];
    assign tx.ig2       = lanes_q[11:6];
    assign tx.ig3       = lanes_q[17:12];
    assign tx.busy      = busy_q;
    assign state_o      = state_q;

    always_comb begin
        align_cnt_d = align_cnt_q;
        if (state_q == ST_ALIGN) begin
            align_cnt_d = '0;
        end else if (!align_due) begin
            align_cnt_d = align_cnt_q + 16'd1;
        end
    end

    // Lane groups are loaded on the transition so they always show the state being entered.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            beat_q      <= '0;
            align_cnt_q <= ALIGN_MAX;
            lanes_q     <= ctrl_groups(CODE_IDLE);
            busy_q      <= 1'b0;
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            align_cnt_q <= align_cnt_d;
            case (state_q)
                ST_IDLE: begin
                    if (align_due) begin
                        state_q <= ST_ALIGN;
                        lanes_q <= ctrl_groups(CODE_ALIGN);
                    end else if (tx.pkt_valid) begin
                        state_q <= ST_SOF;
                        shift_q <= tx.pkt_i;
                        beat_q  <= '0;
                        lanes_q <= ctrl_groups(CODE_SOF);
                        busy_q  <= 1'b1;
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
                        cksum_q <= '0;
`endif
                    end else begin
                        lanes_q <= ctrl_groups(CODE_IDLE);
                    end
                end
                ST_ALIGN: begin
                    state_q <= ST_IDLE;
                    lanes_q <= ctrl_groups(CODE_IDLE);
                end
                ST_SOF: begin
                    state_q <= ST_DATA;
                    lanes_q <= data_groups(shift_q[14:0]);
                    shift_q <= shift_q >> 15;
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
                    cksum_q <= cksum_d;
`endif
                end
                ST_DATA: begin
                    if (beat_q == 3'd7) begin
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
                        state_q <= ST_CKSUM;
                        lanes_q <= data_groups(cksum_q);
`else
                        state_q <= ST_IDLE;
                        lanes_q <= ctrl_groups(CODE_IDLE);
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        beat_q  <= beat_q + 3'd1;
                        lanes_q <= data_groups(shift_q[14:0]);
                        shift_q <= shift_q >> 15;
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
                        cksum_q <= cksum_d;
`endif
                    end
                end
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
                ST_CKSUM: begin
                    state_q <= ST_IDLE;
                    lanes_q <= ctrl_groups(CODE_IDLE);
                    busy_q  <= 1'b0;
                end
`endif
                default: begin
                    state_q <= ST_IDLE;
                    lanes_q <= ctrl_groups(CODE_IDLE);
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_grid_router_tx_framer.sv
// Self-checking bench for grid_router_tx_framer: frame contents, reset, align timing and collisions.
module tb_grid_router_tx_framer;
    localparam int INTERVAL = 16;
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
    localparam int FRAME_BEATS = 10;
`else
    localparam int FRAME_BEATS = 9;
`endif
    localparam logic [17:0] G_IDLE  = {3{6'h20}};
    localparam logic [17:0] G_SOF   = {3{6'h3C}};
    localparam logic [17:0] G_ALIGN = {3{6'h35}};

    logic       pclk = 1'b0;
    logic       rst  = 1'b1;
    logic [2:0] state_dbg;
    int         cyc = 0;
    int         last_align_cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [17:0] exp_q[$];

    grid_router_tx_framer_if tx();

    grid_router_tx_framer #(.pAlignInterval(INTERVAL)) dut (
        .pclk    (pclk),
        .rst     (rst),
        .tx      (tx),
        .state_o (state_dbg)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    function automatic logic [17:0] obs();
        return {tx.ig3, tx.ig2, tx.ig1};
    endfunction

    function automatic logic [17:0] lanes_of(input logic [14:0] b);
        return {1'b0, b[14:10], 1'b0, b[9:5], 1'b0, b[4:0]};
    endfunction

    function automatic logic [119:0] rand_pkt();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[119:0];
    endfunction

    // Reference frame: SOF, eight beats low-first, then the mod-2^15 sum of the beats.
    function automatic void build_frame(input logic [119:0] p);
        int unsigned sum;
        logic [14:0] b;
        sum = 0;
        exp_q.push_back(G_SOF);
        for (int k = 0; k < 8; k++) begin
            b = p[15*k +: 15];
            sum = sum + int'(b);
            exp_q.push_back(lanes_of(b));
        end
`ifdef GRID_ROUTER_FRAMER_CHKSUM_EN
        b = 15'(sum % 32768);
        exp_q.push_back(lanes_of(b));
`endif
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tx.pkt_valid = 1'b0;
        tx.pkt_i = '0;
        repeat (3) tick();
        checks++;
        if (obs() !== G_IDLE || tx.busy !== 1'b0 || tx.pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL in_reset: lanes=%h busy=%b ready=%b expected lanes=%h busy=0 ready=0",
                     obs(), tx.busy, tx.pkt_ready, G_IDLE);
        end
        rst = 1'b0;
        checks++;
        if (obs() !== G_IDLE || tx.pkt_ready !== 1'b0) begin
            errors++;
            $display("FAIL release_r: lanes=%h ready=%b expected lanes=%h ready=0",
                     obs(), tx.pkt_ready, G_IDLE);
        end
        tick();
        checks++;
        if (obs() !== G_ALIGN || tx.busy !== 1'b0) begin
            errors++;
            $display("FAIL release_r1_align: lanes=%h busy=%b expected lanes=%h busy=0",
                     obs(), tx.busy, G_ALIGN);
        end
        last_align_cyc = cyc;
        tick();
        checks++;
        if (tx.pkt_ready !== 1'b1 || obs() !== G_IDLE) begin
            errors++;
            $display("FAIL release_r2_ready: ready=%b lanes=%h expected ready=1 lanes=%h",
                     tx.pkt_ready, obs(), G_IDLE);
        end
    endtask

    // Offers p in the current (ready) cycle and checks the whole frame plus the trailing IDLE.
    task automatic send_frame(input logic [119:0] p, input string name);
        logic [17:0] e;
        int since;
        bit exp_ready;
        checks++;
        if (tx.pkt_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready_at_t: ready=%b expected 1", name, tx.pkt_ready);
        end
        tx.pkt_i = p;
        tx.pkt_valid = 1'b1;
        build_frame(p);
        tick();
        tx.pkt_valid = 1'b0;
        tx.pkt_i = rand_pkt();
        for (int i = 0; i < FRAME_BEATS; i++) begin
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e || tx.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s_beat%0d: lanes=%h busy=%b expected lanes=%h busy=1",
                         name, i, obs(), tx.busy, e);
            end
            tick();
        end
        since = cyc - last_align_cyc - 1;
        exp_ready = (since < INTERVAL);
        checks++;
        if (obs() !== G_IDLE || tx.busy !== 1'b0 || tx.pkt_ready !== exp_ready) begin
            errors++;
            $display("FAIL %s_tail: lanes=%h busy=%b ready=%b expected lanes=%h busy=0 ready=%b",
                     name, obs(), tx.busy, tx.pkt_ready, G_IDLE, exp_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
    endtask

    task automatic test_zero_packet();
        do_reset();
        send_frame('0, "zeros");
    endtask

    task automatic test_incrementing_packet();
        logic [119:0] p;
        for (int k = 0; k < 8; k++) p[15*k +: 15] = 15'(k + 1);
        do_reset();
        send_frame(p, "incr");
    endtask

    task automatic test_ones_packet();
        do_reset();
        send_frame({120{1'b1}}, "ones");
    endtask

    task automatic test_random_packets();
        for (int n = 0; n < 6; n++) begin
            do_reset();
            send_frame(rand_pkt(), "rand");
        end
    endtask

    task automatic test_back_to_back();
        int since;
        bit due;
        do_reset();
        send_frame(rand_pkt(), "b2b_first");
        send_frame(rand_pkt(), "b2b_second");
        since = cyc - last_align_cyc - 1;
        due = (since >= INTERVAL);
        if (due) begin
            tick();
            checks++;
            if (obs() !== G_ALIGN || tx.busy !== 1'b0) begin
                errors++;
                $display("FAIL b2b_align_after_frame: lanes=%h busy=%b expected lanes=%h busy=0",
                         obs(), tx.busy, G_ALIGN);
            end
            tick();
            checks++;
            if (obs() !== G_IDLE || tx.pkt_ready !== 1'b1) begin
                errors++;
                $display("FAIL b2b_ready_after_align: lanes=%h ready=%b expected lanes=%h ready=1",
                         obs(), tx.pkt_ready, G_IDLE);
            end
        end
    endtask

    task automatic test_align_collision();
        logic [17:0] e;
        int last_seen;
        int aligns;
        int frames;
        int gap;
        do_reset();
        last_seen = last_align_cyc;
        aligns = 0;
        frames = 0;
        exp_q.delete();
        tx.pkt_valid = 1'b1;
        tx.pkt_i = rand_pkt();
        for (int c = 0; c < 200; c++) begin
            checks++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (obs() !== e || tx.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL collide_frame_c%0d: lanes=%h busy=%b expected lanes=%h busy=1",
                             c, obs(), tx.busy, e);
                end
            end else if ((obs() !== G_IDLE && obs() !== G_ALIGN) || tx.busy !== 1'b0) begin
                errors++;
                $display("FAIL collide_gap_c%0d: lanes=%h busy=%b expected IDLE/ALIGN busy=0",
                         c, obs(), tx.busy);
            end
            if (obs() === G_ALIGN) begin
                aligns++;
                gap = cyc - last_seen - 1;
                checks++;
                if (gap > INTERVAL + FRAME_BEATS + 1) begin
                    errors++;
                    $display("FAIL collide_align_gap: gap=%0d required at most %0d",
                             gap, INTERVAL + FRAME_BEATS + 1);
                end
                last_seen = cyc;
            end
            if (tx.pkt_ready === 1'b1) begin
                frames++;
                build_frame(tx.pkt_i);
            end
            tick();
            tx.pkt_i = rand_pkt();
        end
        tx.pkt_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                errors++;
                $display("FAIL collide_drain: lanes=%h expected %h", obs(), e);
            end
            tick();
        end
        checks++;
        if (aligns < 4 || frames < 4) begin
            errors++;
            $display("FAIL collide_activity: aligns=%0d frames=%0d expected at least 4 each",
                     aligns, frames);
        end
    endtask

    task automatic test_midframe_reset();
        logic [119:0] p;
        do_reset();
        p = rand_pkt();
        tx.pkt_i = p;
        tx.pkt_valid = 1'b1;
        tick();
        tx.pkt_valid = 1'b0;
        repeat (4) tick();
        checks++;
        if (obs() !== lanes_of(p[45 +: 15])) begin
            errors++;
            $display("FAIL midrst_beat3: lanes=%h expected %h", obs(), lanes_of(p[45 +: 15]));
        end
        rst = 1'b1;
        tick();
        checks++;
        if (obs() !== G_IDLE || tx.busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_abort: lanes=%h busy=%b expected lanes=%h busy=0",
                     obs(), tx.busy, G_IDLE);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (obs() !== G_ALIGN) begin
            errors++;
            $display("FAIL midrst_align: lanes=%h expected %h", obs(), G_ALIGN);
        end
        for (int c = 0; c < 20; c++) begin
            tick();
            checks++;
            if ((obs() !== G_IDLE && obs() !== G_ALIGN) || tx.busy !== 1'b0) begin
                errors++;
                $display("FAIL midrst_no_leftover_c%0d: lanes=%h busy=%b expected IDLE/ALIGN busy=0",
                         c, obs(), tx.busy);
            end
        end
    endtask

    initial begin
        tx.pkt_valid = 1'b0;
        tx.pkt_i = '0;
        test_reset();
        test_zero_packet();
        test_incrementing_packet();
        test_ones_packet();
        test_random_packets();
        test_back_to_back();
        test_align_collision();
        test_midframe_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
